// File: rtl/calltrace_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : calltrace_dump_if
// Brief    : Bundles the dump sequencer's stack-side and IO-side signals.
//            master = the dump sequencer, slave = the stack plus IO decoder.
// Revision : 1.0  initial release
// ============================================================================
interface calltrace_dump_if #(
  parameter int DW = 24
);
  // Trigger and stack side
  logic          trig;
  logic [DW-1:0] st_data;
  logic          st_empty;
  logic          st_frozen;
  logic          st_rd;
  logic          st_wr_ctrl;
  logic [2:0]    st_ctrl;
  // IO decoder side
  logic          io_wr_ctrl;
  logic          io_rd_data;
  logic [31:0]   io_data_in;
  logic [31:0]   io_data_out;
  logic [31:0]   io_status_out;
  logic          irq;

  modport master (
    input  trig, st_data, st_empty, st_frozen, io_wr_ctrl, io_rd_data, io_data_in,
    output st_rd, st_wr_ctrl, st_ctrl, io_data_out, io_status_out, irq
  );

  modport slave (
    output trig, st_data, st_empty, st_frozen, io_wr_ctrl, io_rd_data, io_data_in,
    input  st_rd, st_wr_ctrl, st_ctrl, io_data_out, io_status_out, irq
  );
endinterface
`default_nettype wire

// File: rtl/calltrace_dump.sv
`default_nettype none
// ============================================================================
// Module   : calltrace_dump
// Brief    : Error-time sequencer for the calltrace stack. On a trigger it
//            freezes the stack, drains it newest-first into a local snapshot,
//            raises irq, serves IO reads, then clears and unfreezes the stack
//            on software release.
// Options  : CALLTRACE_DUMP_TS_EN - latch a free-running cycle counter at
//            dump start, readable as the word just past the last entry.
// Revision : 1.0  initial release
// ============================================================================
module calltrace_dump #(
  parameter int SLOTS = 64,
  parameter int DW    = 24
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  calltrace_dump_if.master bus
);

  localparam int c_AW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FREEZE = 3'd1,
    S_POP    = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_CLEAR  = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_trig_q;
  // Counters are one bit wider than the status field so SLOTS=256 can be held.
  logic [8:0]    r_n_entries;
  logic [8:0]    r_rd_ptr;
  logic          r_ovfl;
  logic          r_st_rd;
  logic          r_st_wr_ctrl;
  logic [2:0]    r_st_ctrl;
  logic          r_irq;
  logic [DW-1:0] r_snap [SLOTS];

  logic          w_start;
  logic          w_release;
  logic          w_rewind;
  logic          w_full;
  logic          w_snap_we;
  logic          w_busy;
  logic          w_done;
  logic [31:0]   w_ts_word;
  logic [31:0]   w_data_out;
  logic          w_unused;

  assign w_start   = (bus.trig & ~r_trig_q) | (bus.io_wr_ctrl & bus.io_data_in[0]);
  assign w_release = bus.io_wr_ctrl & bus.io_data_in[1];
  assign w_rewind  = bus.io_wr_ctrl & bus.io_data_in[2];
  assign w_full    = (r_n_entries == 9'(SLOTS));
  assign w_snap_we = (r_state == S_POP) & ~bus.st_empty & ~w_full;
  assign w_busy    = (r_state == S_FREEZE) | (r_state == S_POP) |
                     (r_state == S_WAIT)   | (r_state == S_CLEAR);
  assign w_done    = (r_state == S_DONE);

  // Stack frozen flag is informational only; the sequencer never waits on it.
  assign w_unused  = &{1'b0, bus.st_frozen, bus.io_data_in[31:3]};

  // Sequencer: freeze, drain one entry every two cycles, hold for software, clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_trig_q     <= 1'b0;
      r_n_entries  <= '0;
      r_rd_ptr     <= '0;
      r_ovfl       <= 1'b0;
      r_st_rd      <= 1'b0;
      r_st_wr_ctrl <= 1'b0;
      r_st_ctrl    <= 3'b000;
      r_irq        <= 1'b0;
    end else begin
      r_trig_q     <= bus.trig;
      r_st_rd      <= 1'b0;
      r_st_wr_ctrl <= 1'b0;
      r_st_ctrl    <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state      <= S_FREEZE;
            r_n_entries  <= '0;
            r_rd_ptr     <= '0;
            r_ovfl       <= 1'b0;
            r_st_wr_ctrl <= 1'b1;
            r_st_ctrl    <= 3'b010;
          end
        end
        S_FREEZE: r_state <= S_POP;
        S_POP: begin
          if (bus.st_empty) begin
            r_state <= S_DONE;
            r_irq   <= 1'b1;
          end else if (w_full) begin
            r_ovfl  <= 1'b1;
            r_state <= S_DONE;
            r_irq   <= 1'b1;
          end else begin
            r_n_entries <= r_n_entries + 9'd1;
            r_st_rd     <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: r_state <= S_POP;
        S_DONE: begin
          if (bus.io_rd_data && (r_rd_ptr < r_n_entries))
            r_rd_ptr <= r_rd_ptr + 9'd1;
          if (w_release) begin
            r_state      <= S_CLEAR;
            r_st_wr_ctrl <= 1'b1;
            r_st_ctrl    <= 3'b101;
          end else if (w_rewind) begin
            r_rd_ptr <= '0;
          end
        end
        S_CLEAR: begin
          r_state <= S_IDLE;
          r_irq   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Snapshot RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_snap_we)
      r_snap[r_n_entries[c_AW-1:0]] <= bus.st_data;
  end

`ifdef CALLTRACE_DUMP_TS_EN
  logic [31:0] r_cycle;
  logic [31:0] r_ts;

  // Free-running cycle counter, captured when a dump is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= '0;
      r_ts    <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if ((r_state == S_IDLE) && w_start)
        r_ts <= r_cycle;
    end
  end

  assign w_ts_word = r_ts;
`else
  assign w_ts_word = '0;
`endif

  // Read mux: live entries, then the timestamp word in DONE, otherwise zero.
  always_comb begin
    w_data_out = '0;
    if (r_rd_ptr < r_n_entries)
      w_data_out[DW-1:0] = r_snap[r_rd_ptr[c_AW-1:0]];
    else if (w_done && (r_rd_ptr == r_n_entries))
      w_data_out = w_ts_word;
  end

  assign bus.io_data_out   = w_data_out;
  assign bus.io_status_out = {8'b0, r_n_entries[7:0], r_rd_ptr[7:0], 5'b0, r_ovfl, w_busy, w_done};
  assign bus.st_rd         = r_st_rd;
  assign bus.st_wr_ctrl    = r_st_wr_ctrl;
  assign bus.st_ctrl       = r_st_ctrl;
  assign bus.irq           = r_irq;

endmodule
`default_nettype wire
